// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, payload layout and helpers for pipeline stage chains
//
// Purpose : common definitions for the generic inter-stage pipeline register
//           (pipe_stage_chain) and its per-slot register (pipe_slot).
// Contents: NOP encoding, default payload width, maximum chain depth,
//           IF/ID payload field offsets, packed payload struct and helpers.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam int          PIPE_PAYLOAD_W = 64;
  localparam int          PIPE_MAX_DEPTH = 8;

  // Field offsets inside a {PC_Plus_4, Instruction} payload.
  localparam int          PC_LSB         = 32;
  localparam int          INSTR_LSB      = 0;

  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
  } if_id_payload_t;

  // Builds an IF/ID payload word from its two fields.
  function automatic logic [PIPE_PAYLOAD_W-1:0] pack_if_id(
    input logic [31:0] pc_plus_4,
    input logic [31:0] instr
  );
    if_id_payload_t p;
    p.pc_plus_4 = pc_plus_4;
    p.instr     = instr;
    return p;
  endfunction

  // True when an OCC_W-bit counter can hold every count 0..max_count.
  function automatic bit occ_fits(input int occ_w, input int max_count);
    return (64'(1) << occ_w) > 64'(max_count);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+data register of a pipeline stage chain
//
// Purpose : single slot of the chain; updates on the falling clock edge.
//           i_flush has priority and turns the slot into a bubble holding
//           FLUSH_VAL. i_load captures the upstream valid/data; an invalid
//           upstream payload is stored as FLUSH_VAL so bubbles are always
//           clean. With neither asserted the slot holds.
// Ports   : i_clk            clock (state changes on negedge)
//           i_flush          synchronous clear (reset or flush)
//           i_load           capture i_valid/i_data this edge
//           i_valid, i_data  upstream valid bit and payload
//           o_valid, o_data  registered valid bit and payload
module pipe_slot #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(negedge i_clk) begin
    if (i_flush) begin
      r_valid <= 1'b0;
      r_data  <= FLUSH_VAL;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_data  <= i_valid ? i_data : FLUSH_VAL;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - parametrised valid/ready pipeline register chain with flush
//
// Purpose : DEPTH back-to-back slots of DATA_W payload between two pipeline
//           stages, with stall back-pressure, bubble collapsing and
//           flush-to-bubble. All state changes on the falling clock edge.
// Macro   : PIPE_SKID_EN - adds one skid entry ahead of slot 0 so In_Ready is
//           a registered signal with no combinational path from Out_Ready.
// Ports   : Clk        clock (negedge active)
//           Reset      synchronous active-high reset
//           In_Valid   upstream payload present
//           In_Ready   chain accepts In_Data this edge
//           In_Data    upstream payload
//           Out_Valid  last slot holds a live payload
//           Out_Ready  downstream consumes Out_Data this edge
//           Out_Data   last slot payload (FLUSH_VAL when not valid)
//           Flush      drop every in-flight payload
//           Occupancy  valid payloads held (slots + skid)
// Params  : DATA_W, DEPTH (1..PIPE_MAX_DEPTH), FLUSH_VAL, OCC_W
//           (2**OCC_W must exceed DEPTH+1).
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = PIPE_PAYLOAD_W,
  parameter int                DEPTH     = 1,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter int                OCC_W     = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  input  logic              Flush,
  output logic [OCC_W-1:0]  Occupancy
);

  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  logic [DEPTH-1:0]  w_valid;
  logic [DATA_W-1:0] w_data [DEPTH];
  logic [DEPTH-1:0]  w_move;
  logic [DEPTH-1:0]  w_load;
  logic              w_clear;
  logic              w_src_valid;
  logic [DATA_W-1:0] w_src_data;
  logic              w_xfer_in;
  logic              w_xfer_out;
  logic [OCC_W-1:0]  r_occ;

  assign w_clear = Reset | Flush;

  // A valid slot advances when every slot ahead of it up to the next bubble
  // is valid and moving; equivalently, when there is a bubble somewhere
  // ahead, or the whole run to the tail is full and downstream is ready.
  // Scanning from the tail with a running "all valid above" flag avoids a
  // bit-to-bit combinational chain on w_move.
  always_comb begin : p_move
    logic full_above;
    full_above = 1'b1;
    w_move     = '0;
    w_load     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_move[i]  = w_valid[i] & (Out_Ready | ~full_above);
      w_load[i]  = ~w_valid[i] | w_move[i];
      full_above = full_above & w_valid[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    if (g == 0) begin : g_head
      pipe_slot #(
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_VAL)
      ) u_slot (
        .i_clk   (Clk),
        .i_flush (w_clear),
        .i_load  (w_load[g]),
        .i_valid (w_src_valid),
        .i_data  (w_src_data),
        .o_valid (w_valid[g]),
        .o_data  (w_data[g])
      );
    end else begin : g_body
      pipe_slot #(
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_VAL)
      ) u_slot (
        .i_clk   (Clk),
        .i_flush (w_clear),
        .i_load  (w_load[g]),
        .i_valid (w_valid[g-1]),
        .i_data  (w_data[g-1]),
        .o_valid (w_valid[g]),
        .o_data  (w_data[g])
      );
    end
  end

`ifdef PIPE_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;

  // The skid entry is older than anything on In_Data, so it feeds slot 0
  // first. While it is occupied the input is closed, which keeps In_Ready a
  // pure register output.
  assign w_src_valid = r_skid_valid | In_Valid;
  assign w_src_data  = r_skid_valid ? r_skid_data : In_Data;
  assign In_Ready    = ~r_skid_valid;

  always_ff @(negedge Clk) begin
    if (w_clear) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= FLUSH_VAL;
    end else if (r_skid_valid) begin
      if (w_load[0]) begin
        r_skid_valid <= 1'b0;
        r_skid_data  <= FLUSH_VAL;
      end
    end else if (In_Valid & ~w_load[0]) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= In_Data;
    end
  end
`else
  assign w_src_valid = In_Valid;
  assign w_src_data  = In_Data;
  assign In_Ready    = w_load[0];
`endif

  assign w_xfer_in  = In_Valid & In_Ready;
  assign w_xfer_out = w_valid[DEPTH-1] & Out_Ready;

  // Flush wins over both transfers; whatever left on the flush edge is
  // simply gone along with everything else, so the count goes to zero.
  always_ff @(negedge Clk) begin
    if (w_clear) begin
      r_occ <= '0;
    end else begin
      case ({w_xfer_in, w_xfer_out})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign Out_Valid = w_valid[DEPTH-1];
  assign Out_Data  = w_data[DEPTH-1];
  assign Occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - self-checking bench for pipe_stage_chain at DEPTH 1, 2 and 3
module tb_pipe_stage_chain;

  localparam int NI = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        In_Valid = 1'b0;
  logic [63:0] In_Data = 64'h0;
  logic        Out_Ready = 1'b0;
  logic        Flush = 1'b0;

  logic        in_ready  [NI];
  logic        out_valid [NI];
  logic [63:0] out_data  [NI];
  logic [3:0]  occ       [NI];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pipe_stage_chain #(
      .DATA_W    (64),
      .DEPTH     (g + 1),
      .FLUSH_VAL (64'h0),
      .OCC_W     (4)
    ) u_dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .In_Valid  (In_Valid),
      .In_Ready  (in_ready[g]),
      .In_Data   (In_Data),
      .Out_Valid (out_valid[g]),
      .Out_Ready (Out_Ready),
      .Out_Data  (out_data[g]),
      .Flush     (Flush),
      .Occupancy (occ[g])
    );
  end

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s depth=%0d got=%h want=%h t=%0t", name, inst + 1, act, exp, $time);
    end
  endtask

  // Reference model: each instance holds an ordered list of live payloads
  // (oldest first) tagged with their slot position, plus an optional skid
  // entry. Each edge every payload moves one position toward the tail unless
  // the payload ahead of it blocks; the oldest leaves from the tail when the
  // consumer is ready.
  logic [63:0] m_data [NI][9];
  int          m_pos  [NI][9];
  int          m_cnt  [NI] = '{0, 0, 0};
  bit          m_skv  [NI] = '{0, 0, 0};
  logic [63:0] m_skd  [NI];

  function automatic bit mdl_free0(input int i);
    int d = i + 1;
    int bound = d;
    for (int k = 0; k < m_cnt[i]; k++) begin
      if (k == 0 && m_pos[i][0] == d - 1 && Out_Ready) continue;
      bound = (m_pos[i][k] + 1 < bound - 1) ? m_pos[i][k] + 1 : bound - 1;
    end
    return bound > 0;
  endfunction

  task automatic mdl_step(input int i);
    int          d = i + 1;
    int          nc = 0;
    int          bound = d;
    int          p;
    bit          f0;
    logic [63:0] nd [9];
    int          np [9];
    if (Reset || Flush) begin
      m_cnt[i] = 0;
      m_skv[i] = 1'b0;
      return;
    end
    f0 = mdl_free0(i);
    for (int k = 0; k < m_cnt[i]; k++) begin
      if (k == 0 && m_pos[i][0] == d - 1 && Out_Ready) continue;
      p = (m_pos[i][k] + 1 < bound - 1) ? m_pos[i][k] + 1 : bound - 1;
      nd[nc] = m_data[i][k];
      np[nc] = p;
      nc++;
      bound = p;
    end
`ifdef PIPE_SKID_EN
    if (m_skv[i]) begin
      if (f0) begin
        nd[nc] = m_skd[i]; np[nc] = 0; nc++;
        m_skv[i] = 1'b0;
      end
    end else if (In_Valid) begin
      if (f0) begin
        nd[nc] = In_Data; np[nc] = 0; nc++;
      end else begin
        m_skv[i] = 1'b1;
        m_skd[i] = In_Data;
      end
    end
`else
    if (In_Valid && f0) begin
      nd[nc] = In_Data; np[nc] = 0; nc++;
    end
`endif
    for (int k = 0; k < nc; k++) begin
      m_data[i][k] = nd[k];
      m_pos[i][k]  = np[k];
    end
    m_cnt[i] = nc;
  endtask

  // Compare process: outputs after each negedge, with the inputs currently
  // applied, against the model; then advance the model by one edge.
  always @(posedge Clk) begin
    if (run) begin
      #2;
      for (int i = 0; i < NI; i++) begin
        bit          ev;
        bit          er;
        logic [63:0] ed;
        ev = (m_cnt[i] > 0) && (m_pos[i][0] == i);
        ed = ev ? m_data[i][0] : 64'h0;
`ifdef PIPE_SKID_EN
        er = ~m_skv[i];
`else
        er = mdl_free0(i);
`endif
        chk("out_valid", i, 64'(out_valid[i]), 64'(ev));
        chk("out_data",  i, out_data[i], ed);
        chk("in_ready",  i, 64'(in_ready[i]), 64'(er));
        chk("occupancy", i, 64'(occ[i]), 64'(m_cnt[i] + int'(m_skv[i])));
      end
      for (int i = 0; i < NI; i++) mdl_step(i);
    end
  end

  task automatic drive(input bit iv, input logic [63:0] d, input bit ordy, input bit fl, input bit rst);
    @(posedge Clk);
    #1;
    In_Valid  = iv;
    In_Data   = d;
    Out_Ready = ordy;
    Flush     = fl;
    Reset     = rst;
  endtask

  initial begin
    @(negedge Clk);
    run = 1'b1;

    // Reset state.
    drive(1, 64'hDEAD_BEEF_0000_0001, 0, 1, 1);
    drive(0, 64'h0, 1, 0, 0);
    #2;
    chk("rst_out_valid", 0, 64'(out_valid[0]), 64'h0);
    chk("rst_out_data",  0, out_data[0], 64'h0);
    chk("rst_in_ready",  0, 64'(in_ready[0]), 64'h1);
    chk("rst_occ",       0, 64'(occ[0]), 64'h0);

    // DEPTH=1 streaming.
    drive(1, 64'h00000004_8C010000, 1, 0, 0);
    drive(1, 64'h00000008_8C020004, 1, 0, 0);
    #2;
    chk("stream_data0", 0, out_data[0], 64'h00000004_8C010000);
    chk("stream_occ0",  0, 64'(occ[0]), 64'h1);
    drive(0, 64'h0, 1, 0, 0);
    #2;
    chk("stream_data1", 0, out_data[0], 64'h00000008_8C020004);
    chk("stream_occ1",  0, 64'(occ[0]), 64'h1);

    // DEPTH=3 stall with four payloads offered, then one release edge.
    drive(0, 64'h0, 0, 1, 0);
    drive(1, 64'h1111, 0, 0, 0);
    drive(1, 64'h2222, 0, 0, 0);
    drive(1, 64'h3333, 0, 0, 0);
    drive(1, 64'h4444, 0, 0, 0);
`ifndef PIPE_SKID_EN
    #2;
    chk("stall_in_ready", 2, 64'(in_ready[2]), 64'h0);
    chk("stall_occ",      2, 64'(occ[2]), 64'h3);
    chk("stall_head",     2, out_data[2], 64'h1111);
`endif
    drive(1, 64'h4444, 1, 0, 0);
`ifndef PIPE_SKID_EN
    #2;
    chk("release_in_ready", 2, 64'(in_ready[2]), 64'h1);
`endif
    drive(0, 64'h0, 0, 0, 0);
`ifndef PIPE_SKID_EN
    #2;
    chk("release_occ",  2, 64'(occ[2]), 64'h3);
    chk("release_head", 2, out_data[2], 64'h2222);
    chk("full_d2_occ",  1, 64'(occ[1]), 64'h2);
`endif

    // DEPTH=2 flush while full with an input offered.
    drive(1, 64'h5555, 0, 1, 0);
    drive(0, 64'h0, 1, 0, 0);
    #2;
    chk("flush_valid", 1, 64'(out_valid[1]), 64'h0);
    chk("flush_data",  1, out_data[1], 64'h0);
    chk("flush_occ",   1, 64'(occ[1]), 64'h0);
    drive(0, 64'h0, 1, 0, 0);
    drive(0, 64'h0, 1, 0, 0);
    #2;
    chk("flush_no_deliver", 1, 64'(out_valid[1]), 64'h0);

    // DEPTH=3 bubble collapse under stall.
    drive(1, 64'hA0A0, 0, 0, 0);
    drive(0, 64'h0, 0, 0, 0);
    drive(1, 64'hB0B0, 0, 0, 0);
    drive(0, 64'h0, 0, 0, 0);
    drive(0, 64'h0, 0, 0, 0);
    #2;
    chk("gap_occ",  2, 64'(occ[2]), 64'h2);
    chk("gap_head", 2, out_data[2], 64'hA0A0);
    drive(0, 64'h0, 1, 0, 0);
    drive(0, 64'h0, 0, 0, 0);
    #2;
    chk("gap_second", 2, out_data[2], 64'hB0B0);
    chk("gap_second_valid", 2, 64'(out_valid[2]), 64'h1);

`ifdef PIPE_SKID_EN
    // DEPTH=1 skid fill, ordered drain, reset mid-stall.
    drive(0, 64'h0, 0, 1, 0);
    drive(1, 64'hC001, 0, 0, 0);
    drive(1, 64'hC002, 0, 0, 0);
    drive(1, 64'hC003, 0, 0, 0);
    #2;
    chk("skid_in_ready", 0, 64'(in_ready[0]), 64'h0);
    chk("skid_occ",      0, 64'(occ[0]), 64'h2);
    drive(0, 64'h0, 1, 0, 0);
    #2;
    chk("skid_first", 0, out_data[0], 64'hC001);
    drive(0, 64'h0, 1, 0, 0);
    #2;
    chk("skid_second", 0, out_data[0], 64'hC002);
    drive(1, 64'hC004, 0, 0, 0);
    drive(1, 64'hC005, 0, 0, 0);
    drive(1, 64'hC006, 0, 0, 0);
    #2;
    chk("skid_refill_occ", 0, 64'(occ[0]), 64'h2);
    drive(0, 64'h0, 0, 0, 1);
    drive(0, 64'h0, 0, 0, 0);
    #2;
    chk("skid_reset_occ", 0, 64'(occ[0]), 64'h0);
`endif

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(99) < 70, {$urandom, $urandom}, $urandom_range(99) < 60,
            $urandom_range(99) < 4, $urandom_range(299) == 0);
    end
    drive(0, 64'h0, 1, 0, 0);
    @(posedge Clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
